// File: rtl/nibble_feeder_pkg.sv
// Shared types and constants for the nibble feeder: serializer state
// encoding, datapath widths and the FIFO occupancy-counter width helper.
package nibble_feeder_pkg;

    localparam int NIBBLE_W = 4;
    localparam int BYTE_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        SECOND
    } state_t;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous DEPTH x BYTE_W FIFO with registered pointers and occupancy
// count. Head byte is presented combinationally on rdata while not empty.
module byte_fifo
    import nibble_feeder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [BYTE_W-1:0]         wdata,
    input  logic                      pop,
    output logic [BYTE_W-1:0]         rdata,
    output logic [count_w(DEPTH)-1:0] count,
    output logic                      full,
    output logic                      empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_w(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nibble_feeder.sv
// Byte-to-nibble feeder for the accumulator datapath. Bytes are buffered
// in byte_fifo and emitted as two nibbles on consecutive cycles; data is
// held at zero whenever no nibble is being sent.
// Optional build macro NIBBLE_FEEDER_STATS_EN adds bytes_sent and
// overflow_seen statistics outputs.
module nibble_feeder
    import nibble_feeder_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [BYTE_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [NIBBLE_W-1:0]       data,
    output logic                      data_valid,
    output logic                      busy,
    output logic [count_w(DEPTH)-1:0] fifo_count
`ifdef NIBBLE_FEEDER_STATS_EN
    ,
    output logic [15:0]               bytes_sent,
    output logic                      overflow_seen
`endif
);

    logic [BYTE_W-1:0]   head;
    logic                full;
    logic                empty;
    logic                pop;
    logic [NIBBLE_W-1:0] first_nib;
    logic [NIBBLE_W-1:0] second_nib;
    logic [NIBBLE_W-1:0] hold;
    state_t              state;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .wdata (in_data),
        .pop   (pop),
        .rdata (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    // Ready comes from the registered count only: no bypass when full.
    assign in_ready   = !full;
    assign pop        = (state != FIRST) && !empty;
    assign busy       = (fifo_count != '0) || (state != IDLE);
    assign first_nib  = (MSB_FIRST != 0) ? head[7:4] : head[3:0];
    assign second_nib = (MSB_FIRST != 0) ? head[3:0] : head[7:4];

    // Serializer FSM: pop a byte, send its first nibble, then the held second.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            data       <= '0;
            data_valid <= 1'b0;
            hold       <= '0;
        end else begin
            case (state)
                FIRST: begin
                    data       <= hold;
                    data_valid <= 1'b1;
                    state      <= SECOND;
                end
                default: begin
                    if (!empty) begin
                        data       <= first_nib;
                        hold       <= second_nib;
                        data_valid <= 1'b1;
                        state      <= FIRST;
                    end else begin
                        data       <= '0;
                        data_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef NIBBLE_FEEDER_STATS_EN
    // Statistics: bytes completed (FIRST->SECOND) and sticky push-while-full.
    always_ff @(posedge clk) begin
        if (reset) begin
            bytes_sent    <= '0;
            overflow_seen <= 1'b0;
        end else begin
            if (state == FIRST) begin
                bytes_sent <= bytes_sent + 1'b1;
            end
            if (in_valid && !in_ready) begin
                overflow_seen <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nibble_feeder.sv
// Scoreboard testbench for nibble_feeder (DEPTH=4, MSB_FIRST=1).
module tb_nibble_feeder;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    data;
    logic          data_valid;
    logic          busy;
    logic [CW-1:0] fifo_count;
`ifdef NIBBLE_FEEDER_STATS_EN
    logic [15:0]   bytes_sent;
    logic          overflow_seen;
`endif

    nibble_feeder #(
        .DEPTH     (DEPTH),
        .MSB_FIRST (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data       (data),
        .data_valid (data_valid),
        .busy       (busy),
        .fifo_count (fifo_count)
`ifdef NIBBLE_FEEDER_STATS_EN
        ,
        .bytes_sent    (bytes_sent),
        .overflow_seen (overflow_seen)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit started = 0;

    // Reference model: expected nibble stream, bytes buffered, and how many
    // nibbles of the current byte are still being shown (2 = first, 1 = second).
    logic [3:0] exp_q[$];
    int         mcount = 0;
    int         mrem = 0;
    int         mbytes = 0;
    bit         movf = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each edge from pre-edge inputs.
    always @(posedge clk) begin
        bit acc;
        if (reset) begin
            exp_q.delete();
            mcount = 0;
            mrem = 0;
            mbytes = 0;
            movf = 0;
        end else begin
            acc = in_valid && (mcount < DEPTH);
            if (in_valid && mcount == DEPTH) movf = 1;
            if (mrem == 2) begin
                mrem = 1;
                mbytes = (mbytes + 1) & 16'hFFFF;
            end else if (mcount > 0) begin
                mrem = 2;
                mcount--;
            end else begin
                mrem = 0;
            end
            if (acc) begin
                mcount++;
                exp_q.push_back(in_data[7:4]);
                exp_q.push_back(in_data[3:0]);
            end
        end
    end

    // Monitor: compare DUT outputs against the model just after each edge.
    always begin
        logic [3:0] nib;
        @(posedge clk);
        #1;
        if (started) begin
            check("data_valid", data_valid, mrem != 0);
            if (data_valid === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL nibble_unexpected: got %0h expected none at %0t", data, $time);
                end else begin
                    nib = exp_q.pop_front();
                    if (data !== nib) begin
                        fails++;
                        $display("FAIL nibble: got %0h expected %0h at %0t", data, nib, $time);
                    end
                end
            end else begin
                check("idle_data", data, 0);
            end
            check("fifo_count", fifo_count, mcount);
            check("in_ready", in_ready, mcount < DEPTH);
            check("busy", busy, (mcount != 0) || (mrem != 0));
`ifdef NIBBLE_FEEDER_STATS_EN
            check("bytes_sent", bytes_sent, mbytes);
            check("overflow_seen", overflow_seen, movf);
`endif
        end
    end

    // Offer a byte and hold it until the feeder is ready to take it.
    task automatic send(input logic [7:0] b);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("send_accept", guard < 200, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
    endtask

    initial begin
        logic [7:0] stream [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        int g;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        @(posedge clk);
        started = 1;
        @(negedge clk);
        reset = 1'b0;

        idle(10);

        send(8'hA5);
        idle(6);

        foreach (stream[i]) send(stream[i]);
        send(8'h77);
        idle(20);

        // Reset while the second nibble of 0x9C is on data with two bytes queued.
        send(8'h9C);
        send(8'h11);
        send(8'h22);
        @(negedge clk);
        in_valid = 1'b0;
        g = 0;
        while (!(data_valid && data == 4'hC) && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("reach_second_9c", g < 20, 1);
        check("queued_before_reset", fifo_count, 2);
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("post_reset_data", data, 0);
        check("post_reset_count", fifo_count, 0);
        @(negedge clk);
        reset = 1'b0;
        idle(10);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
            reset    = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        idle(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
